// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared FSM state and request-owner encodings for mem_arbiter
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter : two-port (fetch/data) arbiter onto a single memory port with
//               ack timeout. Define MEM_ARBITER_RR_EN for round-robin grants.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          i_i_req,
  input  logic [AW-1:0] i_i_addr,
  output logic          o_i_vd,
  output logic [DW-1:0] o_i_rdata,
  // data port
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_vd,
  output logic [DW-1:0] o_d_rdata,
  // memory port
  output logic          o_mem_re,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  // status
  output logic          o_busy,
  output logic          o_err
);

  import mem_arb_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

`ifdef MEM_ARBITER_RR_EN
  localparam bit c_RR_EN = 1'b1;
`elsif MEM_ARB_RR_EN
  localparam bit c_RR_EN = 1'b1;
`else
  localparam bit c_RR_EN = 1'b0;
`endif

  state_t        state;
  owner_t        owner;
  logic          we_lat;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          grant_d;
  logic          tmo_hit;

  assign any_req = i_i_req | i_d_req;
  assign o_busy  = (state != IDLE);
  // Counter would reach TIMEOUT at the end of this MEM cycle.
  assign tmo_hit = (cnt == CW'(TIMEOUT - 1));

  generate
    if (c_RR_EN) begin : g_rr
      owner_t rr_ptr;

      always_comb begin
        grant_d = i_d_req & (~i_i_req | (rr_ptr == OWN_D));
      end

      // Pointer always points away from the port granted last.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rr_ptr <= OWN_D;
        end else if (state == IDLE && any_req) begin
          rr_ptr <= grant_d ? OWN_I : OWN_D;
        end
      end
    end else begin : g_fixed
      always_comb begin
        grant_d = i_d_req;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_I;
      we_lat      <= 1'b0;
      cnt         <= '0;
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_i_vd      <= 1'b0;
      o_d_vd      <= 1'b0;
      o_err       <= 1'b0;
      o_i_rdata   <= '0;
      o_d_rdata   <= '0;
    end else begin
      o_i_vd <= 1'b0;
      o_d_vd <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= MEM;
            cnt   <= '0;
            if (grant_d) begin
              owner       <= OWN_D;
              we_lat      <= i_d_we;
              o_mem_addr  <= i_d_addr;
              o_mem_wdata <= i_d_wdata;
              o_mem_re    <= ~i_d_we;
              o_mem_we    <= i_d_we;
            end else begin
              owner       <= OWN_I;
              we_lat      <= 1'b0;
              o_mem_addr  <= i_i_addr;
              o_mem_wdata <= '0;
              o_mem_re    <= 1'b1;
              o_mem_we    <= 1'b0;
            end
          end
        end
        MEM: begin
          if (i_mem_ack || tmo_hit) begin
            state    <= RESP;
            o_mem_re <= 1'b0;
            o_mem_we <= 1'b0;
            o_err    <= ~i_mem_ack;
            o_i_vd   <= (owner == OWN_I);
            o_d_vd   <= (owner == OWN_D);
            if (i_mem_ack && !we_lat) begin
              if (owner == OWN_D) begin
                o_d_rdata <= i_mem_rdata;
              end else begin
                o_i_rdata <= i_mem_rdata;
              end
            end
          end
          if (!i_mem_ack) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter : randomized scoreboard bench for mem_arbiter with a
//                  transaction-level memory and arbitration model.
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR_MODE = 1'b1;
`elsif MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_i_req = 1'b0;
  logic [AW-1:0] i_i_addr = '0;
  logic          i_d_req = 1'b0;
  logic          i_d_we = 1'b0;
  logic [AW-1:0] i_d_addr = '0;
  logic [DW-1:0] i_d_wdata = '0;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ack;
  logic          o_i_vd, o_d_vd, o_mem_re, o_mem_we, o_busy, o_err;
  logic [DW-1:0] o_i_rdata, o_d_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_i_req(i_i_req), .i_i_addr(i_i_addr), .o_i_vd(o_i_vd), .o_i_rdata(o_i_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_vd(o_d_vd), .o_d_rdata(o_d_rdata),
    .o_mem_re(o_mem_re), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = acked, 1 = never acked (timeout), 2 = aborted by reset
  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            delay;
    int            kind;
  } plan_t;

  typedef struct {
    bit            is_d;
    bit            err;
    logic [DW-1:0] rdata;
  } exp_t;

  plan_t         plan_q[$];
  exp_t          exp_q[$];
  int            vdcyc_q[$];
  logic [DW-1:0] mem_m [logic [AW-1:0]];
  logic [DW-1:0] last_i = '0;
  logic [DW-1:0] last_d = '0;
  bit            ptr_d = 1'b1;
  int            total = 0;
  int            bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
  endfunction

  function automatic logic [DW-1:0] memval(logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // One served transaction, taken in grant order.
  function automatic void model_txn(bit is_d, bit we, logic [AW-1:0] a,
                                    logic [DW-1:0] wd, int kind, int delay);
    plan_t p;
    exp_t  e;
    p.we    = we;
    p.addr  = a;
    p.wdata = wd;
    p.kind  = kind;
    p.delay = delay;
    p.rdata = we ? DW'($urandom) : memval(a);
    if (kind == 0 && we) mem_m[a] = wd;
    if (kind == 0 && !we) begin
      if (is_d) last_d = p.rdata;
      else      last_i = p.rdata;
    end
    e.is_d  = is_d;
    e.err   = (kind == 1);
    e.rdata = is_d ? last_d : last_i;
    plan_q.push_back(p);
    exp_q.push_back(e);
  endfunction

  task automatic run_round(bit ri, bit rd, bit dwe, logic [AW-1:0] ia, logic [AW-1:0] da,
                           logic [DW-1:0] dwd, int ik, int idl, int dk, int ddl);
    bit d_first;
    bit pend_i, pend_d;
    int n;
    if (ri && rd) d_first = RR_MODE ? ptr_d : 1'b1;
    else          d_first = rd;
    if (d_first) begin
      if (rd) model_txn(1'b1, dwe, da, dwd, dk, ddl);
      if (ri) model_txn(1'b0, 1'b0, ia, '0, ik, idl);
    end else begin
      if (ri) model_txn(1'b0, 1'b0, ia, '0, ik, idl);
      if (rd) model_txn(1'b1, dwe, da, dwd, dk, ddl);
    end
    if (ri || rd) ptr_d = !((ri && rd) ? !d_first : rd);
    @(negedge clk);
    i_i_req = ri; i_i_addr = ia;
    i_d_req = rd; i_d_we = dwe; i_d_addr = da; i_d_wdata = dwd;
    pend_i = ri;
    pend_d = rd;
    n = 0;
    while ((pend_i || pend_d) && n < 4 * (TO + 10)) begin
      @(negedge clk);
      n++;
      if (o_i_vd) begin i_i_req = 1'b0; pend_i = 1'b0; end
      if (o_d_vd) begin i_d_req = 1'b0; pend_d = 1'b0; end
    end
    if (pend_i || pend_d) begin
      fail_now("round_no_completion");
      i_i_req = 1'b0;
      i_d_req = 1'b0;
    end
  endtask

  // Memory responder: verifies each strobe against the plan and acks on schedule.
  initial begin
    plan_t p;
    int    n;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      i_mem_ack   = 1'b0;
      i_mem_rdata = DW'($urandom);
      if (o_mem_re || o_mem_we) begin
        if (plan_q.size() == 0) begin
          fail_now("unexpected_strobe");
          while (o_mem_re || o_mem_we) @(negedge clk);
        end else begin
          p = plan_q.pop_front();
          check("strobe_kind", {o_mem_we, o_mem_re}, {p.we, !p.we});
          check("strobe_addr", o_mem_addr, p.addr);
          if (p.we) check("strobe_wdata", o_mem_wdata, p.wdata);
          if (p.kind == 0) begin
            repeat (p.delay) begin
              @(negedge clk);
              check("addr_hold", {(o_mem_re | o_mem_we), o_mem_addr}, {1'b1, p.addr});
            end
            i_mem_ack   = 1'b1;
            i_mem_rdata = p.rdata;
            vdcyc_q.push_back(cyc + 1);
            @(negedge clk);
            i_mem_ack = 1'b0;
          end else begin
            if (p.kind == 1) vdcyc_q.push_back(cyc + TO);
            n = 0;
            while ((o_mem_re || o_mem_we) && n < TO + 20) begin
              @(negedge clk);
              n++;
            end
            if (p.kind == 1) check("timeout_mem_cycles", n, TO);
          end
        end
      end else if ($urandom_range(0, 4) == 0) begin
        i_mem_ack   = 1'b1;   // stray ack outside MEM
        i_mem_rdata = DW'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard on every completion pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_i_vd || o_d_vd) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_vd");
          end else begin
            e = exp_q.pop_front();
            check("vd_port", {o_d_vd, o_i_vd}, e.is_d ? 2'b10 : 2'b01);
            check("err_flag", o_err, e.err);
            check(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? o_d_rdata : o_i_rdata, e.rdata);
            check("busy_in_resp", o_busy, 1'b1);
            if (vdcyc_q.size() == 0) fail_now("vd_without_mem_event");
            else check("vd_cycle", cyc, vdcyc_q.pop_front());
          end
        end else if (o_err) begin
          fail_now("err_without_vd");
        end
      end
    end
  end

  task automatic check_idle_zero(string tag);
    check({tag, "_flags"}, {o_mem_re, o_mem_we, o_i_vd, o_d_vd, o_busy, o_err}, '0);
    check({tag, "_addr"}, o_mem_addr, '0);
    check({tag, "_wdata"}, o_mem_wdata, '0);
    check({tag, "_i_rdata"}, o_i_rdata, '0);
    check({tag, "_d_rdata"}, o_d_rdata, '0);
  endtask

  initial begin
    plan_t p;
    repeat (2) @(negedge clk);
    check_idle_zero("reset_during");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_after");

    // single fetch
    mem_m[32'h100] = 32'h0000_0013;
    run_round(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 0, 2, 0, 0);
    // contention: data write first, fetch second
    run_round(1'b1, 1'b1, 1'b1, 32'h104, 32'h2000, 32'hDEAD_BEEF, 0, 1, 0, 0);
    // data read-back, then a timed-out read that must leave o_d_rdata alone
    run_round(1'b0, 1'b1, 1'b0, '0, 32'h2000, '0, 0, 0, 0, 3);
    run_round(1'b0, 1'b1, 1'b0, '0, 32'h3000, '0, 0, 0, 1, 0);
    // back-to-back fetches
    run_round(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 0, 0, 0, 0);
    run_round(1'b1, 1'b0, 1'b0, 32'h2000, '0, '0, 0, 3, 0, 0);

    for (int r = 0; r < 150; r++) begin
      run_round(1'($urandom), 1'($urandom), 1'($urandom),
                {26'd0, 4'($urandom), 2'b00}, {26'd0, 4'($urandom), 2'b00}, DW'($urandom),
                ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset while the memory strobe is up
    @(negedge clk);
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h40;
    p.we = 1'b0; p.addr = 32'h40; p.wdata = '0; p.rdata = '0; p.delay = 0; p.kind = 2;
    plan_q.push_back(p);
    @(negedge clk);
    i_d_req = 1'b0;
    check("abort_strobe_up", {o_mem_re, o_busy}, 2'b11);
    #2 rst = 1'b1;
    #1 check_idle_zero("abort_async");
    last_i = '0;
    last_d = '0;
    ptr_d  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_round(1'b1, 1'b1, 1'b0, 32'h100, 32'h2000, '0, 0, 1, 0, 2);

    repeat (4) @(negedge clk);
    check("queues_drained", plan_q.size() + exp_q.size() + vdcyc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
